fpu_bus_if: RTL and testbench

Peripheral-side bus interface of the FPU. It decodes the 8-bit host bus (chip select, read and write strobes, all active-low), holds the operand and operation registers, and launches the arithmetic core. It captures the core's result, raises the end-of-command interrupt, and releases it on host acknowledge. It sits between the system databus and the FPU arithmetic core; the core itself is outside this block.

---
 rtl/fpu_bus_if.sv | 166 ++++++++++++++++
 tb/tb_fpu_bus_if.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_bus_if.sv
// Purpose: host-side register interface of the FPU. It holds the operands and op code,
//          launches the arithmetic core, and captures the result behind a level IRQ.
// Latency: a write is visible from the edge after commit. core_start follows the start
//          commit edge by one cycle. The result and cmd_end appear on the core_done edge.
// Backpressure: none on the host bus. Operand writes are dropped while RUN, and a start
//          outside IDLE only sets the sticky overrun flag.
//
// Ports:
//   clk, arst_n          clock, asynchronous active-low reset
//   databus_in/out       8-bit host data; out is 0x00 unless cs=0 and rd=0
//   addr, cs, rd, wr     register address and active-low strobes
//   end_ack              host acknowledge of cmd_end (active-high)
//   cmd_end, busy        end-of-command IRQ level, command-in-progress
//   core_a/b/op          operand and op code registers, driven straight to the core
//   core_start           one-cycle launch pulse to the core
//   core_done/result     completion pulse and result from the core
module fpu_bus_if #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [7:0]  databus_in,
    output logic [7:0]  databus_out,
    input  logic [3:0]  addr,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic        end_ack,
    output logic        cmd_end,
    output logic        busy,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic [7:0]  core_op,
    output logic        core_start,
    input  logic        core_done,
    input  logic [31:0] core_result
);

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    // The counter value seen on the edge where the RUN cycle count reaches TIMEOUT_CYCLES.
    localparam logic [15:0] TC_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        wr_q;
    logic        rd_q;
    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [7:0]  reg_op;
    logic [31:0] result;
    logic        overrun;
    logic        timeout;
    logic [15:0] cnt;
    logic [7:0]  rd_data;

    logic        wr_commit;
    logic        start_wr;
    logic        status_rd;
    logic        terminal;

    // A strobe edge only counts when the strobe was high on the previous edge.
    // This way a strobe held low for many cycles commits exactly once.
    assign wr_commit = ~cs & ~wr & wr_q;
    assign start_wr  = wr_commit & (addr == 4'd9);
    assign status_rd = ~cs & ~rd & rd_q & (addr == 4'd13);
    assign terminal  = (cnt == TC_LAST);

    assign core_a  = reg_a;
    assign core_b  = reg_b;
    assign core_op = reg_op;
    assign busy    = (state == RUN);
    assign cmd_end = (state == DONE);

    // Next-state logic. core_done takes priority over the timeout terminal count.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_wr)               state_nxt = RUN;
            RUN:  if (core_done || terminal)  state_nxt = DONE;
            DONE: if (end_ack)                state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            wr_q       <= 1'b1;
            rd_q       <= 1'b1;
            reg_a      <= '0;
            reg_b      <= '0;
            reg_op     <= '0;
            result     <= '0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
            cnt        <= '0;
            core_start <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_q       <= wr;
            rd_q       <= rd;
            core_start <= (state == IDLE) && start_wr;

            // Operands stay frozen while the core is working on them.
            if (wr_commit && state != RUN) begin
                case (addr)
                    4'd0, 4'd1, 4'd2, 4'd3: reg_a[{addr[1:0], 3'b000} +: 8] <= databus_in;
                    4'd4, 4'd5, 4'd6, 4'd7: reg_b[{addr[1:0], 3'b000} +: 8] <= databus_in;
                    4'd8:                   reg_op <= databus_in;
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (start_wr) begin
                        cnt     <= '0;
                        timeout <= 1'b0;
                    end
                end
                RUN: begin
                    if (core_done) begin
                        result <= core_result;
                    end else if (terminal) begin
                        result  <= QNAN;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: ;
            endcase

            // If a stray start and a status read ever coincide, the set wins.
            // The host then still sees the overrun on its next status read.
            if (start_wr && state != IDLE)
                overrun <= 1'b1;
            else if (status_rd)
                overrun <= 1'b0;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            4'd0, 4'd1, 4'd2, 4'd3: rd_data = reg_a[{addr[1:0], 3'b000} +: 8];
            4'd4, 4'd5, 4'd6, 4'd7: rd_data = reg_b[{addr[1:0], 3'b000} +: 8];
            4'd8:                   rd_data = reg_op;
            4'd9:                   rd_data = result[7:0];
            4'd10:                  rd_data = result[15:8];
            4'd11:                  rd_data = result[23:16];
            4'd12:                  rd_data = result[31:24];
            4'd13:                  rd_data = {5'b00000, overrun, timeout, busy};
            default:                rd_data = 8'h00;
        endcase
    end

    assign databus_out = (!cs && !rd) ? rd_data : 8'h00;

endmodule

// File: tb/tb_fpu_bus_if.sv
// Purpose: directed bench for fpu_bus_if. Host reads are scoreboarded, and other outputs are checked inline.
// Latency: inputs change 1 ns after the rising edge, and outputs are sampled on the falling edge.
// Backpressure: none; a small behavioural core model answers core_start after a programmable delay.
module tb_fpu_bus_if;

    localparam int TMO = 24;

    logic        clk;
    logic        arst_n;
    logic [7:0]  databus_in;
    logic [7:0]  databus_out;
    logic [3:0]  addr;
    logic        cs;
    logic        rd;
    logic        wr;
    logic        end_ack;
    logic        cmd_end;
    logic        busy;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic [7:0]  core_op;
    logic        core_start;
    logic        core_done;
    logic [31:0] core_result;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [3:0] exp_addr_q[$];

    int          core_delay = 0;
    logic [31:0] core_res   = '0;

    fpu_bus_if #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .databus_in (databus_in),
        .databus_out(databus_out),
        .addr       (addr),
        .cs         (cs),
        .rd         (rd),
        .wr         (wr),
        .end_ack    (end_ack),
        .cmd_end    (cmd_end),
        .busy       (busy),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_op    (core_op),
        .core_start (core_start),
        .core_done  (core_done),
        .core_result(core_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each host read cycle pops one expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (arst_n && !cs && !rd) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_unexpected: addr %0d got 0x%02h, expected no read", addr, databus_out);
                end else begin
                    automatic logic [7:0] e  = exp_q.pop_front();
                    automatic logic [3:0] ea = exp_addr_q.pop_front();
                    if (databus_out !== e || addr !== ea) begin
                        errors++;
                        $display("FAIL read_addr%0d: got 0x%02h at addr %0d, expected 0x%02h", ea, databus_out, addr, e);
                    end
                end
            end
        end
    end

    // Behavioural core. It raises core_done so that the pulse is sampled core_delay edges after the start commit.
    initial begin
        core_done   = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            if (core_start && core_delay > 0) begin
                repeat (core_delay - 1) @(negedge clk);
                core_result = core_res;
                core_done   = 1'b1;
                @(negedge clk);
                core_done   = 1'b0;
            end
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        addr = a; databus_in = d; cs = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        wr = 1'b1; cs = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [7:0] exp);
        @(posedge clk); #1;
        exp_q.push_back(exp);
        exp_addr_q.push_back(a);
        addr = a; cs = 1'b0; rd = 1'b0;
        @(posedge clk); #1;
        rd = 1'b1; cs = 1'b1;
    endtask

    // Counts the busy cycles that follow a start commit, bounded by a cycle budget.
    task automatic run_count(output int nbusy, output int nstart, output logic end_seen);
        nbusy = 0; nstart = 0; end_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            nstart += int'(core_start);
            if (busy) nbusy++;
            else begin
                end_seen = cmd_end;
                break;
            end
        end
    endtask

    task automatic wait_end(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_end) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic ack(input string name);
        @(posedge clk); #1;
        end_ack = 1'b1;
        @(negedge clk);
        check({name, "_cmd_end_before_ack"}, 32'(cmd_end), 32'd1);
        @(posedge clk); #1;
        end_ack = 1'b0;
        @(negedge clk);
        check({name, "_cmd_end_after_ack"}, 32'(cmd_end), 32'd0);
        check({name, "_busy_after_ack"}, 32'(busy), 32'd0);
    endtask

    int   nb;
    int   ns;
    logic es;
    logic late_end;

    initial begin
        arst_n = 1'b0; cs = 1'b1; rd = 1'b1; wr = 1'b1;
        addr = '0; databus_in = '0; end_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_end", 32'(cmd_end), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_core_a", core_a, 32'd0);
        check("rst_core_b", core_b, 32'd0);
        check("rst_core_op", 32'(core_op), 32'd0);
        check("rst_databus_out", 32'(databus_out), 32'd0);
        arst_n = 1'b1;
        bus_read(4'd8, 8'h00);
        bus_read(4'd9, 8'h00);
        bus_read(4'd13, 8'h00);

        // Normal command: the core answers 20 cycles after the start.
        bus_write(4'd0, 8'hFF); bus_write(4'd1, 8'hFF);
        bus_write(4'd2, 8'hFF); bus_write(4'd3, 8'h3F);
        bus_write(4'd4, 8'hDA); bus_write(4'd5, 8'h0F);
        bus_write(4'd6, 8'h49); bus_write(4'd7, 8'h40);
        bus_write(4'd8, 8'h03);
        @(negedge clk);
        check("t1_core_a", core_a, 32'h3FFF_FFFF);
        check("t1_core_b", core_b, 32'h4049_0FDA);
        check("t1_core_op", 32'(core_op), 32'h03);
        bus_read(4'd3, 8'h3F);
        bus_read(4'd8, 8'h03);
        core_delay = 20; core_res = 32'h3F22_F983;
        bus_write(4'd9, 8'hA5);
        run_count(nb, ns, es);
        check("t1_busy_cycles", 32'(nb), 32'd20);
        check("t1_start_pulses", 32'(ns), 32'd1);
        check("t1_cmd_end_rise", 32'(es), 32'd1);
        bus_read(4'd9, 8'h83);
        bus_read(4'd10, 8'hF9);
        bus_read(4'd11, 8'h22);
        bus_read(4'd12, 8'h3F);
        ack("t1");

        // A strobe held low for 5 cycles with changing data must commit only the first byte.
        @(posedge clk); #1;
        addr = 4'd0; databus_in = 8'h55; cs = 1'b0; wr = 1'b0;
        for (int i = 1; i < 5; i++) begin
            @(posedge clk); #1;
            databus_in = 8'(8'h60 + i);
        end
        @(posedge clk); #1;
        wr = 1'b1; cs = 1'b1;
        bus_read(4'd0, 8'h55);
        bus_write(4'd0, 8'h12);
        bus_write(4'd1, 8'h34);
        bus_read(4'd0, 8'h12);
        bus_read(4'd1, 8'h34);

        // Operand write and second start during RUN.
        core_delay = 20; core_res = 32'h0000_0001;
        bus_write(4'd9, 8'h00);
        bus_write(4'd0, 8'hAA);
        bus_write(4'd9, 8'h00);
        bus_read(4'd0, 8'h12);
        bus_read(4'd13, 8'h05);
        bus_read(4'd13, 8'h01);
        @(negedge clk);
        check("t3_core_a_frozen", core_a, 32'h3FFF_3412);
        wait_end("t3_cmd_end");
        ack("t3");

        // Timeout: the core never answers.
        core_delay = 0;
        bus_write(4'd9, 8'h00);
        run_count(nb, ns, es);
        check("t4_busy_cycles", 32'(nb), 32'(TMO));
        check("t4_cmd_end_rise", 32'(es), 32'd1);
        bus_read(4'd9, 8'h00);
        bus_read(4'd10, 8'h00);
        bus_read(4'd11, 8'hC0);
        bus_read(4'd12, 8'h7F);
        bus_read(4'd13, 8'h02);
        ack("t4");
        core_delay = 3; core_res = 32'h1111_2222;
        bus_write(4'd9, 8'h00);
        bus_read(4'd13, 8'h01);
        wait_end("t4b_cmd_end");
        bus_read(4'd9, 8'h22);
        ack("t4b");

        // core_done lands on the terminal-count edge, so done wins.
        core_delay = TMO; core_res = 32'h0BAD_F00D;
        bus_write(4'd9, 8'h00);
        run_count(nb, ns, es);
        check("t5_busy_cycles", 32'(nb), 32'(TMO));
        check("t5_cmd_end_rise", 32'(es), 32'd1);
        bus_read(4'd9, 8'h0D);
        bus_read(4'd12, 8'h0B);
        bus_read(4'd13, 8'h00);
        ack("t5");

        // Asynchronous reset mid-RUN, followed by a late core_done.
        core_delay = 10; core_res = 32'hDEAD_BEEF;
        bus_write(4'd9, 8'h00);
        repeat (3) @(negedge clk);
        check("t6_busy_before_rst", 32'(busy), 32'd1);
        arst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_cmd_end", 32'(cmd_end), 32'd0);
        check("t6_rst_core_a", core_a, 32'd0);
        check("t6_rst_core_op", 32'(core_op), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        late_end = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            late_end = late_end | cmd_end | busy;
        end
        check("t6_late_done_ignored", 32'(late_end), 32'd0);
        bus_read(4'd0, 8'h00);
        bus_read(4'd8, 8'h00);
        bus_read(4'd9, 8'h00);
        bus_read(4'd13, 8'h00);

        repeat (2) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
